axis_dma_byte_unpacker: RTL and testbench

Upstream neighbour of the integrated VGA component. It takes the 32-bit AXI-Stream words delivered by the PS DMA and serialises them into the 8-bit AXI-Stream pixel bytes that the VGA component consumes. It also checks DMA framing (TLAST) against a fixed frame length and reports mismatches. It runs in the VGA pixel-side clock domain, with no CDC.

---
 rtl/vga_stream_pkg.sv | 32 +++
 rtl/axis_dma_byte_unpacker.sv | 143 ++++++++++++++
 tb/tb_axis_dma_byte_unpacker.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_stream_pkg.sv
// -----------------------------------------------------------------------------
// vga_stream_pkg
// Definitions shared between the DMA byte unpacker and the VGA component:
//   state_e          - unpacker holding-register state (ST_EMPTY, ST_DRAIN)
//   FRAME_BYTES_DEF  - default frame length, 320x240 pixels at 8 bpp
//   ERR_CNT_W        - width of the saturating framing-error counter
//   KEEP_MAX_W       - widest TKEEP the helper function accepts
//   last_byte_idx()  - index of the highest set TKEEP bit (0 when none set)
// -----------------------------------------------------------------------------
package vga_stream_pkg;

   typedef enum logic {
      ST_EMPTY,
      ST_DRAIN
   } state_e;

   localparam int unsigned FRAME_BYTES_DEF = 76800;
   localparam int unsigned ERR_CNT_W       = 8;
   localparam int unsigned KEEP_MAX_W      = 64;

   // Only the highest enable matters: lower bytes are emitted regardless of
   // their own enable bit, so a non-contiguous TKEEP still drains predictably.
   function automatic int unsigned last_byte_idx(input logic [KEEP_MAX_W-1:0] keep);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
         if (keep[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/axis_dma_byte_unpacker.sv
// -----------------------------------------------------------------------------
// axis_dma_byte_unpacker
// Serialises IN_BYTES-wide DMA AXI-Stream words into 8-bit pixel bytes (byte 0
// first) and checks TLAST framing against a fixed frame length.
// Ports:
//   i_CLK, i_RST                 clock, synchronous active-high reset
//   S_AXIS_TDATA/TKEEP/TLAST     input word, byte enables, end of DMA frame
//   S_AXIS_TVALID/TREADY         input handshake (TREADY combinational)
//   M_AXIS_DATA/VALID/READY      output pixel byte and handshake
//   M_AXIS_LAST                  marks the byte with frame count FRAME_BYTES-1
//   o_FRAME_ERR                  one-cycle pulse after a mismatched byte
//   o_ERR_CNT                    saturating count of framing errors
// -----------------------------------------------------------------------------
module axis_dma_byte_unpacker
   import vga_stream_pkg::*;
#(
   parameter int unsigned IN_BYTES    = 4,
   parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF
) (
   input  logic                    i_CLK,
   input  logic                    i_RST,
   input  logic [8*IN_BYTES-1:0]   S_AXIS_TDATA,
   input  logic [IN_BYTES-1:0]     S_AXIS_TKEEP,
   input  logic                    S_AXIS_TLAST,
   input  logic                    S_AXIS_TVALID,
   output logic                    S_AXIS_TREADY,
   output logic [7:0]              M_AXIS_DATA,
   output logic                    M_AXIS_VALID,
   input  logic                    M_AXIS_READY,
   output logic                    M_AXIS_LAST,
   output logic                    o_FRAME_ERR,
   output logic [ERR_CNT_W-1:0]    o_ERR_CNT
);

   localparam int unsigned IDX_W = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
   localparam int unsigned CNT_W = $clog2(FRAME_BYTES);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(FRAME_BYTES - 1);

   state_e                     state_q, state_d;
   logic [IN_BYTES-1:0][7:0]   word_q, word_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [IDX_W-1:0]           lidx_q, lidx_d;
   logic                       tlast_q, tlast_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [7:0]                 data_q, data_d;
   logic                       valid_q, valid_d;
   logic                       mlast_q, mlast_d;
   logic                       ferr_q, ferr_d;
   logic [ERR_CNT_W-1:0]       errc_q, errc_d;

   logic             last_byte;
   logic             m_hs;
   logic             s_ready;
   logic             s_hs;
   logic             end_f;
   logic             tl_f;
   logic [CNT_W-1:0] cnt_next;

   assign last_byte = (idx_q == lidx_q);
   assign m_hs      = valid_q && M_AXIS_READY;
   // Taking the next word on the final byte's handshake gives zero bubble.
   assign s_ready   = !i_RST && ((state_q == ST_EMPTY) || (last_byte && m_hs));
   assign s_hs      = S_AXIS_TVALID && s_ready;
   assign end_f     = (cnt_q == CNT_END);
   assign tl_f      = tlast_q && last_byte;
   // A short frame resyncs on TLAST, a long one wraps at the frame end.
   assign cnt_next  = (end_f || tl_f) ? '0 : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      lidx_d  = lidx_q;
      tlast_d = tlast_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      mlast_d = mlast_q;
      ferr_d  = 1'b0;
      errc_d  = errc_q;

      if (m_hs) begin
         cnt_d  = cnt_next;
         ferr_d = end_f ^ tl_f;
         if ((end_f ^ tl_f) && (errc_q != '1)) errc_d = errc_q + 1'b1;
         if (!last_byte) begin
            idx_d   = idx_q + 1'b1;
            data_d  = word_q[idx_q + 1'b1];
            mlast_d = (cnt_next == CNT_END);
         end else begin
            valid_d = 1'b0;
            state_d = ST_EMPTY;
         end
      end

      // An all-zero TKEEP word is swallowed: nothing loads, TLAST is ignored.
      if (s_hs && (|S_AXIS_TKEEP)) begin
         word_d  = S_AXIS_TDATA;
         lidx_d  = IDX_W'(last_byte_idx(KEEP_MAX_W'(S_AXIS_TKEEP)));
         tlast_d = S_AXIS_TLAST;
         idx_d   = '0;
         data_d  = S_AXIS_TDATA[7:0];
         valid_d = 1'b1;
         mlast_d = (cnt_d == CNT_END);
         state_d = ST_DRAIN;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q <= ST_EMPTY;
         idx_q   <= '0;
         lidx_q  <= '0;
         tlast_q <= 1'b0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         mlast_q <= 1'b0;
         ferr_q  <= 1'b0;
         errc_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lidx_q  <= lidx_d;
         tlast_q <= tlast_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         mlast_q <= mlast_d;
         ferr_q  <= ferr_d;
         errc_q  <= errc_d;
      end
      word_q <= word_d;
   end

   assign S_AXIS_TREADY = s_ready;
   assign M_AXIS_DATA   = data_q;
   assign M_AXIS_VALID  = valid_q;
   assign M_AXIS_LAST   = mlast_q;
   assign o_FRAME_ERR   = ferr_q;
   assign o_ERR_CNT     = errc_q;

endmodule

// File: tb/tb_axis_dma_byte_unpacker.sv
module tb_axis_dma_byte_unpacker;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        s_tlast;
   logic        s_tvalid;
   logic        s_tready;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        frame_err;
   logic [7:0]  err_cnt;

   always #5 clk = ~clk;

   axis_dma_byte_unpacker #(.IN_BYTES(4), .FRAME_BYTES(8)) dut (
      .i_CLK        (clk),
      .i_RST        (rst),
      .S_AXIS_TDATA (s_tdata),
      .S_AXIS_TKEEP (s_tkeep),
      .S_AXIS_TLAST (s_tlast),
      .S_AXIS_TVALID(s_tvalid),
      .S_AXIS_TREADY(s_tready),
      .M_AXIS_DATA  (m_data),
      .M_AXIS_VALID (m_valid),
      .M_AXIS_READY (m_ready),
      .M_AXIS_LAST  (m_last),
      .o_FRAME_ERR  (frame_err),
      .o_ERR_CNT    (err_cnt)
   );

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   typedef struct {
      logic [7:0] d;
      logic       last;
      logic       lastb;
   } byte_t;

   word_t wq[$];
   byte_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // frame model
   int m_cnt;
   int exp_err_total;
   int exp_err_run;
   int exp_bytes_run;

   // per-run observations
   int s_hs_n, err_pulses, gap, first_s, first_v, last_seen, bytes_out;
   int s_cyc[$];

   task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      word_t w;
      w.d = d; w.k = k; w.l = l;
      wq.push_back(w);
   endtask

   // Expected byte stream for one accepted word (FRAME_BYTES = 8).
   task automatic model_word(input word_t w);
      int n;
      logic e_end, e_tl;
      byte_t e;
      if (w.k == 4'h0) return;
      n = 1;
      for (int i = 0; i < 4; i++) if (w.k[i]) n = i + 1;
      for (int b = 0; b < n; b++) begin
         e.d     = w.d[8*b +: 8];
         e_end   = (m_cnt == 7);
         e_tl    = w.l && (b == n - 1);
         e.last  = e_end;
         e.lastb = (b == n - 1);
         if (e_end != e_tl) begin
            exp_err_run++;
            if (exp_err_total < 255) exp_err_total++;
         end
         m_cnt = (e_end || e_tl) ? 0 : m_cnt + 1;
         exp_bytes_run++;
         sb.push_back(e);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; s_tvalid = 1'b0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_cnt = 0; exp_err_total = 0;
      wq.delete(); sb.delete();
   endtask

   // Drives queued words, pushes expected bytes on each S handshake and
   // pops/compares them on each M handshake.
   task automatic run_stream(input int ready_pct, input int budget);
      int cyc, tail;
      logic stall_prev;
      logic [7:0] pd;
      logic pl;
      byte_t e;
      cyc = 0; tail = 0; stall_prev = 1'b0; pd = '0; pl = 1'b0;
      s_hs_n = 0; err_pulses = 0; gap = 0; first_s = -1; first_v = -1;
      last_seen = 0; bytes_out = 0; exp_err_run = 0; exp_bytes_run = 0;
      s_cyc.delete();
      while ((wq.size() != 0 || sb.size() != 0 || tail < 3) && cyc < budget) begin
         @(negedge clk);
         if (wq.size() != 0) begin
            s_tvalid = 1'b1; s_tdata = wq[0].d; s_tkeep = wq[0].k; s_tlast = wq[0].l;
         end else begin
            s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
         end
         m_ready = ($urandom_range(0, 99) < ready_pct);
         #1;
         if (stall_prev) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
               n_fail++;
               $display("FAIL stall_hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                        m_valid, m_data, m_last, pd, pl);
            end
         end
         if (m_valid === 1'b1 && first_v < 0) first_v = cyc;
         if (m_valid !== 1'b1 && sb.size() != 0 && first_v >= 0) gap++;
         if (frame_err === 1'b1) err_pulses++;
         if (m_valid === 1'b1 && m_ready) begin
            bytes_out++;
            if (m_last === 1'b1) last_seen++;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL extra_byte: got %h with nothing expected", m_data);
            end else begin
               e = sb.pop_front();
               if (m_data !== e.d || m_last !== e.last || s_tready !== e.lastb) begin
                  n_fail++;
                  $display("FAIL byte: data=%h last=%b tready=%b required data=%h last=%b tready=%b",
                           m_data, m_last, s_tready, e.d, e.last, e.lastb);
               end
            end
         end
         if (s_tvalid && s_tready === 1'b1) begin
            model_word(wq.pop_front());
            s_hs_n++;
            s_cyc.push_back(cyc);
            if (first_s < 0) first_s = cyc;
         end
         stall_prev = (m_valid === 1'b1) && !m_ready;
         pd = m_data; pl = m_last;
         if (wq.size() == 0 && sb.size() == 0) tail++;
         cyc++;
      end
      if (wq.size() != 0 || sb.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL timeout: %0d words and %0d bytes outstanding after %0d cycles",
                  wq.size(), sb.size(), cyc);
         wq.delete(); sb.delete();
      end
      @(negedge clk);
      s_tvalid = 1'b0; m_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hA5A5A5A5; s_tkeep = 4'hF; m_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (s_tready !== 1'b0) begin
         n_fail++; $display("FAIL reset_tready: got %b required 0", s_tready);
      end
      @(negedge clk);
      rst = 1'b0; s_tvalid = 1'b0; m_ready = 1'b0;
      m_cnt = 0; exp_err_total = 0; wq.delete(); sb.delete();
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 ||
          frame_err !== 1'b0 || err_cnt !== 8'h00 || s_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b data=%h last=%b err=%b cnt=%0d tready=%b required 0 00 0 0 0 1",
                  m_valid, m_data, m_last, frame_err, err_cnt, s_tready);
      end
   endtask

   task automatic test_single_word();
      apply_reset();
      push_word(32'h44332211, 4'hF, 1'b0);
      run_stream(100, 200);
      n_checks++;
      if (s_hs_n != 1 || bytes_out != 4) begin
         n_fail++; $display("FAIL single_count: words=%0d bytes=%0d required 1 and 4", s_hs_n, bytes_out);
      end
      n_checks++;
      if (first_v - first_s != 1) begin
         n_fail++; $display("FAIL single_latency: got %0d cycles required 1", first_v - first_s);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      for (int i = 0; i < 6; i++) push_word($urandom, 4'hF, (i % 2) == 1);
      run_stream(100, 300);
      n_checks++;
      if (gap != 0) begin
         n_fail++; $display("FAIL b2b_bubble: got %0d idle cycles required 0", gap);
      end
      bad = 0;
      for (int i = 1; i < s_cyc.size(); i++) if (s_cyc[i] - s_cyc[i-1] != 4) bad++;
      n_checks++;
      if (s_hs_n != 6 || bad != 0) begin
         n_fail++; $display("FAIL b2b_spacing: words=%0d bad_gaps=%0d required 6 and 0", s_hs_n, bad);
      end
      n_checks++;
      if (err_pulses != exp_err_run) begin
         n_fail++; $display("FAIL b2b_errs: got %0d required %0d", err_pulses, exp_err_run);
      end
   endtask

   task automatic test_random_backpressure();
      logic [3:0] keeps [6];
      keeps[0] = 4'hF; keeps[1] = 4'hF; keeps[2] = 4'h7;
      keeps[3] = 4'h3; keeps[4] = 4'h1; keeps[5] = 4'h0;
      apply_reset();
      for (int i = 0; i < 1000; i++)
         push_word($urandom, keeps[$urandom_range(0, 5)], ($urandom_range(0, 7) == 0));
      run_stream(50, 30000);
      n_checks++;
      if (bytes_out != exp_bytes_run) begin
         n_fail++; $display("FAIL rand_bytes: got %0d required %0d", bytes_out, exp_bytes_run);
      end
      n_checks++;
      if (err_pulses != exp_err_run) begin
         n_fail++; $display("FAIL rand_err_pulses: got %0d required %0d", err_pulses, exp_err_run);
      end
      n_checks++;
      if (err_cnt !== 8'(exp_err_total)) begin
         n_fail++; $display("FAIL rand_err_cnt: got %0d required %0d", err_cnt, exp_err_total);
      end
   endtask

   task automatic test_frame_good();
      apply_reset();
      push_word(32'h04030201, 4'hF, 1'b0);
      push_word(32'h08070605, 4'hF, 1'b1);
      run_stream(100, 200);
      n_checks++;
      if (last_seen != 1 || err_pulses != 0 || err_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL frame_good: lasts=%0d errs=%0d cnt=%0d required 1 0 0", last_seen, err_pulses, err_cnt);
      end
   endtask

   task automatic test_frame_err();
      apply_reset();
      push_word(32'hA3A2A1A0, 4'hF, 1'b1);
      push_word(32'hB3B2B1B0, 4'hF, 1'b0);
      push_word(32'hEEEEEEEE, 4'h0, 1'b1);
      run_stream(100, 200);
      n_checks++;
      if (err_pulses != 1 || err_cnt !== 8'd1 || bytes_out != 8) begin
         n_fail++;
         $display("FAIL short_frame: errs=%0d cnt=%0d bytes=%0d required 1 1 8", err_pulses, err_cnt, bytes_out);
      end
      push_word(32'h0000C1C0, 4'h3, 1'b1);
      run_stream(100, 200);
      n_checks++;
      if (err_pulses != 1 || err_cnt !== 8'd2 || bytes_out != 2) begin
         n_fail++;
         $display("FAIL keep3_tlast: errs=%0d cnt=%0d bytes=%0d required 1 2 2", err_pulses, err_cnt, bytes_out);
      end
      push_word(32'hD3D2D1D0, 4'hF, 1'b0);
      push_word(32'hE3E2E1E0, 4'hF, 1'b1);
      run_stream(100, 200);
      n_checks++;
      if (err_pulses != 0 || err_cnt !== 8'd2 || last_seen != 1) begin
         n_fail++;
         $display("FAIL resync: errs=%0d cnt=%0d lasts=%0d required 0 2 1", err_pulses, err_cnt, last_seen);
      end
   endtask

   task automatic test_reset_mid_word();
      apply_reset();
      push_word(32'h0000AAFF, 4'hF, 1'b0);
      run_stream(100, 100);
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = 32'hDDCCBBAA; s_tkeep = 4'hF; s_tlast = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      s_tvalid = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'hBB) begin
         n_fail++; $display("FAIL mid_setup: valid=%b data=%h required 1 bb", m_valid, m_data);
      end
      rst = 1'b1; m_ready = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || s_tready !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: valid=%b tready=%b required 0 0", m_valid, s_tready);
      end
      rst = 1'b0;
      m_cnt = 0; exp_err_total = 0; wq.delete(); sb.delete();
      push_word(32'h13121110, 4'hF, 1'b0);
      push_word(32'h17161514, 4'hF, 1'b1);
      run_stream(100, 200);
      n_checks++;
      if (err_pulses != 0 || err_cnt !== 8'd0 || last_seen != 1 || bytes_out != 8) begin
         n_fail++;
         $display("FAIL after_mid_reset: errs=%0d cnt=%0d lasts=%0d bytes=%0d required 0 0 1 8",
                  err_pulses, err_cnt, last_seen, bytes_out);
      end
   endtask

   initial begin
      rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_ready = 1'b0;
      m_cnt = 0; exp_err_total = 0; exp_err_run = 0; exp_bytes_run = 0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_random_backpressure();
      test_frame_good();
      test_frame_err();
      test_reset_mid_word();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
